// File: rtl/shifter_pipelined_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings,
// per-stage control bundle and the level-to-stage placement rule.
package shifter_pipelined_pkg;

   localparam logic [1:0] SHIFT_MODE_LOGICAL    = 2'b00;
   localparam logic [1:0] SHIFT_MODE_ARITHMETIC = 2'b01;
   localparam logic [1:0] SHIFT_MODE_ROTATE     = 2'b10;
   localparam logic [1:0] SHIFT_MODE_RESERVED   = 2'b11;

   // pad is the resolved fill bit for the right-shift frame, not the raw in_pad
   typedef struct packed {
      logic       left;
      logic [1:0] mode;
      logic       pad;
   } shift_ctl_t;

   // First shift level owned by a stage: smallest i with floor(i*stages/levels) >= stage
   function automatic int stage_first_level(input int stage, input int stages, input int levels);
      return (stage * levels + stages - 1) / stages;
   endfunction

endpackage

// File: rtl/shifter_pipelined_stage.sv
// One register stage applying shift levels FIRST_LEVEL..FIRST_LEVEL+LEVEL_COUNT-1 (right-shift frame).
// Latency: 1 cycle. Backpressure: accepts when empty or when its content moves downstream this cycle.
// Optional sticky accumulation under SHIFTER_PIPELINED_STICKY_EN.
module shifter_pipelined_stage
   import shifter_pipelined_pkg::*;
#(
   parameter int  WIDTH       = 32,
   parameter int  FIRST_LEVEL = 0,
   parameter int  LEVEL_COUNT = 1,
   localparam int AMT_W       = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             up_vld,
   output logic             up_rdy,
   input  logic [WIDTH-1:0] up_dat,
   input  logic [AMT_W-1:0] up_amount,
   input  shift_ctl_t       up_ctl,
`ifdef SHIFTER_PIPELINED_STICKY_EN
   input  logic             up_sticky,
   output logic             dn_sticky,
`endif
   output logic             dn_vld,
   input  logic             dn_rdy,
   output logic [WIDTH-1:0] dn_dat,
   output logic [AMT_W-1:0] dn_amount,
   output shift_ctl_t       dn_ctl
);

   localparam logic [WIDTH-1:0] ONES = '1;

   logic             load;
   logic [WIDTH-1:0] shifted;
   logic [AMT_W-1:0] amt_sh;
   int               sh;
`ifdef SHIFTER_PIPELINED_STICKY_EN
   logic             sticky_nxt;
`endif

   assign load   = !dn_vld || dn_rdy;
   assign up_rdy = load;

   always_comb begin
      shifted = up_dat;
      amt_sh  = '0;
      sh      = 0;
`ifdef SHIFTER_PIPELINED_STICKY_EN
      sticky_nxt = up_sticky;
`endif
      for (int j = 0; j < LEVEL_COUNT; j++) begin
         amt_sh = up_amount >> (FIRST_LEVEL + j);
         sh     = 1 << (FIRST_LEVEL + j);
         if (amt_sh[0]) begin
            if (up_ctl.mode == SHIFT_MODE_ROTATE) begin
               shifted = (shifted >> sh) | (shifted << (WIDTH - sh));
            end else begin
`ifdef SHIFTER_PIPELINED_STICKY_EN
               // low bits about to fall off the bottom feed the sticky flag
               if (!up_ctl.left)
                  sticky_nxt = sticky_nxt | (|(shifted & ~(ONES << sh)));
`endif
               shifted = (shifted >> sh) | (up_ctl.pad ? ~(ONES >> sh) : '0);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dn_vld    <= 1'b0;
         dn_dat    <= '0;
         dn_amount <= '0;
         dn_ctl    <= '0;
`ifdef SHIFTER_PIPELINED_STICKY_EN
         dn_sticky <= 1'b0;
`endif
      end else begin
         if (load)
            dn_vld <= up_vld;
         if (load && up_vld) begin
            dn_dat    <= shifted;
            dn_amount <= up_amount;
            dn_ctl    <= up_ctl;
`ifdef SHIFTER_PIPELINED_STICKY_EN
            dn_sticky <= sticky_nxt;
`endif
         end
      end
   end

endmodule

// File: rtl/shifter_pipelined.sv
// Dynamic barrel shifter (logical/arithmetic/rotate, left/right) over STAGES registers; out_sticky with SHIFTER_PIPELINED_STICKY_EN.
// Latency: STAGES cycles, 1 op/cycle. Backpressure: full valid/ready, in_ready combinational from out_ready.
// Left shifts run as bit-reverse, shift right, bit-reverse; the direction flag travels with the data.
module shifter_pipelined
   import shifter_pipelined_pkg::*;
#(
   parameter int  WIDTH        = 32,
   parameter int  STAGES       = 2,
   localparam int AMOUNT_WIDTH = $clog2(WIDTH) + 1
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_data,
   input  logic [AMOUNT_WIDTH-1:0] in_amount,
   input  logic                    in_left,
   input  logic [1:0]              in_mode,
   input  logic                    in_pad,
`ifdef SHIFTER_PIPELINED_STICKY_EN
   output logic                    out_sticky,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data
);

   localparam int LEVELS = $clog2(WIDTH);

   logic             vld_s    [STAGES+1];
   logic             rdy_s    [STAGES+1];
   logic [WIDTH-1:0] dat_s    [STAGES+1];
   logic [LEVELS-1:0] amt_s   [STAGES+1];
   shift_ctl_t       ctl_s    [STAGES+1];
`ifdef SHIFTER_PIPELINED_STICKY_EN
   logic             sticky_s [STAGES+1];
`endif

   logic             is_rotate;
   logic             fill;
   logic             saturate;
   logic [WIDTH-1:0] in_rev;
   logic [WIDTH-1:0] out_rev;
   logic             unused_tail;

   assign is_rotate = (in_mode == SHIFT_MODE_ROTATE);

   // Fill bit as seen in the right-shift frame; reserved mode falls through to logical
   always_comb begin
      fill = in_pad;
      if (in_mode == SHIFT_MODE_ARITHMETIC)
         fill = in_left ? 1'b0 : in_data[WIDTH-1];
      else if (is_rotate)
         fill = 1'b0;
   end

   // Amounts >= WIDTH resolve up front to all-fill; rotate just drops the MSB
   assign saturate = in_amount[AMOUNT_WIDTH-1] && !is_rotate;
   assign in_rev   = {<<{in_data}};

   assign vld_s[0] = in_valid;
   assign dat_s[0] = saturate ? {WIDTH{fill}} : (in_left ? in_rev : in_data);
   assign amt_s[0] = saturate ? '0 : in_amount[LEVELS-1:0];
   assign ctl_s[0] = '{left: in_left, mode: in_mode, pad: fill};
`ifdef SHIFTER_PIPELINED_STICKY_EN
   assign sticky_s[0] = saturate && !in_left && (|in_data);
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int FIRST = stage_first_level(k, STAGES, LEVELS);
      localparam int NEXT  = stage_first_level(k + 1, STAGES, LEVELS);

      shifter_pipelined_stage #(
         .WIDTH       (WIDTH),
         .FIRST_LEVEL (FIRST),
         .LEVEL_COUNT (NEXT - FIRST)
      ) u_stage (
         .clock     (clock),
         .resetn    (resetn),
         .up_vld    (vld_s[k]),
         .up_rdy    (rdy_s[k]),
         .up_dat    (dat_s[k]),
         .up_amount (amt_s[k]),
         .up_ctl    (ctl_s[k]),
`ifdef SHIFTER_PIPELINED_STICKY_EN
         .up_sticky (sticky_s[k]),
         .dn_sticky (sticky_s[k+1]),
`endif
         .dn_vld    (vld_s[k+1]),
         .dn_rdy    (rdy_s[k+1]),
         .dn_dat    (dat_s[k+1]),
         .dn_amount (amt_s[k+1]),
         .dn_ctl    (ctl_s[k+1])
      );
   end

   assign rdy_s[STAGES] = out_ready;
   assign in_ready      = rdy_s[0];
   assign out_valid     = vld_s[STAGES];
   assign out_rev       = {<<{dat_s[STAGES]}};
   assign out_data      = ctl_s[STAGES].left ? out_rev : dat_s[STAGES];
`ifdef SHIFTER_PIPELINED_STICKY_EN
   assign out_sticky    = sticky_s[STAGES];
`endif

   // Remaining amount and mode of the last stage have no consumer at the output
   assign unused_tail = ^{amt_s[STAGES], ctl_s[STAGES].mode, ctl_s[STAGES].pad};

endmodule

// File: tb/tb_shifter_pipelined.sv
// Bench for shifter_pipelined (WIDTH=8, STAGES=2): directed cases with hand-derived results,
// backpressure and reset scenarios, then randomized ops checked against a per-bit reference model.
module tb_shifter_pipelined;
   import shifter_pipelined_pkg::*;

   localparam int WIDTH  = 8;
   localparam int STAGES = 2;
   localparam int AW     = $clog2(WIDTH) + 1;

   logic             clock     = 1'b0;
   logic             resetn    = 1'b0;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data   = '0;
   logic [AW-1:0]    in_amount = '0;
   logic             in_left   = 1'b0;
   logic [1:0]       in_mode   = 2'b00;
   logic             in_pad    = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
`ifdef SHIFTER_PIPELINED_STICKY_EN
   logic             out_sticky;
`endif

   int checks = 0;
   int errors = 0;
   int pushed = 0;
   int popped = 0;
   bit push_done;
   logic [WIDTH-1:0] exp_q [$];
   logic             exp_s_q [$];
   logic [WIDTH-1:0] last_exp = '0;

   always #5 clock = ~clock;

   shifter_pipelined #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clock     (clock),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amount (in_amount),
      .in_left   (in_left),
      .in_mode   (in_mode),
      .in_pad    (in_pad),
`ifdef SHIFTER_PIPELINED_STICKY_EN
      .out_sticky(out_sticky),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: each result bit picked directly from its source position
   function automatic logic [WIDTH-1:0] ref_shift(input logic [WIDTH-1:0] d, input int amt,
                                                   input bit left, input logic [1:0] mode,
                                                   input bit pad, output bit sticky);
      logic [WIDTH-1:0] r;
      bit fill;
      int a;
      a = amt;
      fill = (mode == SHIFT_MODE_ARITHMETIC) ? (left ? 1'b0 : d[WIDTH-1]) : pad;
      if (mode == SHIFT_MODE_ROTATE) a = amt % WIDTH;
      r = '0;
      sticky = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (mode == SHIFT_MODE_ROTATE)
            r[i] = left ? d[(i - a + WIDTH) % WIDTH] : d[(i + a) % WIDTH];
         else if (left)
            r[i] = (i - a >= 0) ? d[i - a] : fill;
         else
            r[i] = (i + a < WIDTH) ? d[i + a] : fill;
      end
      if (!left && mode != SHIFT_MODE_ROTATE)
         for (int j = 0; j < WIDTH; j++)
            if (j < a) sticky = sticky | d[j];
      return r;
   endfunction

   // Called at posedge+1; returns at posedge+1 right after the accepting edge
   task automatic push(input logic [WIDTH-1:0] d, input int amt, input bit left,
                       input logic [1:0] mode, input bit pad,
                       input logic [WIDTH-1:0] ed, input bit es);
      bit hs;
      hs = 1'b0;
      in_data = d; in_amount = AW'(amt); in_left = left; in_mode = mode; in_pad = pad;
      in_valid = 1'b1;
      for (int n = 0; n < 200 && !hs; n++) begin
         @(negedge clock);
         hs = in_ready;
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      if (hs) begin
         exp_q.push_back(ed);
         exp_s_q.push_back(es);
         pushed++;
      end else begin
         check("push_timeout", {31'b0, hs}, 32'd1);
      end
   endtask

   task automatic push_rand();
      logic [WIDTH-1:0] d, ed;
      int amt;
      bit left, pad, es;
      logic [1:0] mode;
      d    = WIDTH'($urandom);
      amt  = $urandom_range(0, 2 * WIDTH - 1);
      left = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      pad  = 1'($urandom_range(0, 1));
      ed   = ref_shift(d, amt, left, mode, pad, es);
      push(d, amt, left, mode, pad, ed, es);
   endtask

   task automatic check_latency(input string tag);
      int lat;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!out_valid && lat < 20);
      check(tag, lat, STAGES);
      @(posedge clock); #1;
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 500 && exp_q.size() != 0; n++) begin
         @(posedge clock); #1;
      end
      check(tag, exp_q.size(), 0);
   endtask

   always @(negedge clock) begin
      if (resetn && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", {31'b0, out_valid}, 32'd0);
         end else begin
            if (out_ready) check("out_data", out_data, exp_q[0]);
            else           check("stall_data", out_data, exp_q[0]);
`ifdef SHIFTER_PIPELINED_STICKY_EN
            check("out_sticky", {31'b0, out_sticky}, {31'b0, exp_s_q[0]});
`endif
            if (out_ready) begin
               last_exp = exp_q.pop_front();
               void'(exp_s_q.pop_front());
               popped++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run still active at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      #12;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_data", out_data, 32'd0);
      @(posedge clock); #1;
      resetn = 1'b1;
      @(negedge clock);
      check("rel_in_ready", {31'b0, in_ready}, 32'd1);
      check("rel_out_valid", {31'b0, out_valid}, 32'd0);
`ifdef SHIFTER_PIPELINED_STICKY_EN
      check("rel_sticky", {31'b0, out_sticky}, 32'd0);
`endif
      @(posedge clock); #1;
      out_ready = 1'b1;

      // Directed cases, expected values worked out by hand
      push(8'hB4, 3, 1'b0, SHIFT_MODE_LOGICAL, 1'b0, 8'h16, 1'b1);
      check_latency("latency_first");
      push(8'hB4, 3, 1'b0, SHIFT_MODE_LOGICAL,    1'b1, 8'hF6, 1'b1);
      push(8'hB4, 2, 1'b0, SHIFT_MODE_LOGICAL,    1'b0, 8'h2D, 1'b0);
      push(8'hB4, 2, 1'b0, SHIFT_MODE_ARITHMETIC, 1'b0, 8'hED, 1'b0);
      push(8'h7F, 9, 1'b0, SHIFT_MODE_ARITHMETIC, 1'b0, 8'h00, 1'b1);
      push(8'h80, 8, 1'b0, SHIFT_MODE_ARITHMETIC, 1'b0, 8'hFF, 1'b1);
      push(8'h81, 1, 1'b1, SHIFT_MODE_ARITHMETIC, 1'b0, 8'h02, 1'b0);
      push(8'hB4, 3, 1'b1, SHIFT_MODE_ROTATE,     1'b0, 8'hA5, 1'b0);
      push(8'hB4, 11, 1'b1, SHIFT_MODE_ROTATE,    1'b0, 8'hA5, 1'b0);
      push(8'hA5, 3, 1'b0, SHIFT_MODE_ROTATE,     1'b0, 8'hB4, 1'b0);
      push(8'hC3, 0, 1'b0, SHIFT_MODE_LOGICAL,    1'b1, 8'hC3, 1'b0);
      push(8'hC3, 0, 1'b1, SHIFT_MODE_ARITHMETIC, 1'b0, 8'hC3, 1'b0);
      push(8'hC3, 0, 1'b0, SHIFT_MODE_ROTATE,     1'b0, 8'hC3, 1'b0);
      push(8'h5A, 0, 1'b1, SHIFT_MODE_RESERVED,   1'b1, 8'h5A, 1'b0);
      push(8'h01, 8, 1'b1, SHIFT_MODE_LOGICAL,    1'b1, 8'hFF, 1'b0);
      push(8'hB4, 3, 1'b0, SHIFT_MODE_RESERVED,   1'b1, 8'hF6, 1'b1);
      drain("drain_directed");
      repeat (2) @(posedge clock);
      #1;
      check("hold_out_valid", {31'b0, out_valid}, 32'd0);
      check("hold_out_data", out_data, 32'hF6);

      // Backpressure: six back-to-back ops against a four-cycle output stall
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               logic [WIDTH-1:0] d;
               d = WIDTH'(8'h13 * (i + 1));
               push(d, 1, 1'b0, SHIFT_MODE_LOGICAL, 1'b0, d >> 1, d[0]);
            end
         end
         begin
            repeat (3) @(negedge clock);
            check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            @(posedge clock); #1;
            out_ready = 1'b1;
            @(negedge clock);
            check("bp_push_pop_ready", {31'b0, in_ready}, 32'd1);
         end
      join
      drain("drain_bp");
      check("bp_count", popped, pushed);

      // Reset with two ops in flight
      out_ready = 1'b0;
      push(8'h3C, 1, 1'b0, SHIFT_MODE_LOGICAL, 1'b0, 8'h1E, 1'b0);
      push(8'h3C, 2, 1'b1, SHIFT_MODE_LOGICAL, 1'b0, 8'hF0, 1'b0);
      #2;
      resetn = 1'b0;
      exp_q.delete();
      exp_s_q.delete();
      pushed = popped;
      #1;
      check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("mid_rst_out_data", out_data, 32'd0);
      @(posedge clock); #1;
      resetn = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("no_stale_out", {31'b0, out_valid}, 32'd0);
      end
      check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clock); #1;
      push(8'h96, 4, 1'b0, SHIFT_MODE_ARITHMETIC, 1'b0, 8'hF9, 1'b0);
      check_latency("latency_after_reset");
      drain("drain_reset");

      // Randomized ops under random output backpressure
      push_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               push_rand();
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clock); #1;
               end
            end
            push_done = 1'b1;
         end
         begin
            while (!push_done) begin
               @(posedge clock); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain("drain_random");
      check("total_count", popped, pushed);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shifter_pipelined.md
Name: shifter_pipelined

Overview:
Dynamic barrel shifter with run-time shift amount, direction and mode (logical, arithmetic, rotate), split into a configurable number of register stages. Valid/ready handshake on input and output with full backpressure. Generalises the static constant-shift block for datapaths (ALU, FP alignment, bitfield extraction) that need one result per cycle at high clock rates.

Parameters:
WIDTH, 32, data width; power of two, >= 2
STAGES, 2, register stages, 1..$clog2(WIDTH); the $clog2(WIDTH) shift levels are spread over the stages (level i sits in stage floor(i*STAGES/$clog2(WIDTH)))
AMOUNT_WIDTH, $clog2(WIDTH)+1, localparam; width of shift amount, so that the value WIDTH is representable

Ports:
clock  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  input operation valid
in_ready  output  1  input accepted when in_valid && in_ready
in_data  input  WIDTH  operand
in_amount  input  AMOUNT_WIDTH  shift amount, 0..2^AMOUNT_WIDTH-1
in_left  input  1  0 = shift right, 1 = shift left
in_mode  input  2  00 logical, 01 arithmetic, 10 rotate, 11 reserved (treated as logical)
in_pad  input  1  pad bit for logical mode
out_valid  output  1  result valid
out_ready  input  1  result accepted when out_valid && out_ready
out_data  output  WIDTH  result

Behaviour:
- Reset (resetn low, async): all stage valid bits 0; out_valid=0; out_data=0; in_ready=1 after reset is released. Reset mid-operation discards every in-flight operation; no partial result ever appears.
- Latency: STAGES cycles from input handshake to out_valid with out_ready held high; throughput 1 op/cycle.
- Pipeline: each stage holds valid, data, remaining amount, left, mode, pad. Stage k loads when it is empty or its content moves to k+1 in the same cycle (bubble-collapsing). in_ready = !stage0_valid || stage0 advancing; out_valid = last stage valid. in_ready is combinational from out_ready; no combinational path from in_* to out_*.
- Left shifts: bit-reverse at input, shift right, bit-reverse at output (direction flag travels with the data).
- Logical: vacated bits = in_pad. Arithmetic right: vacated bits = in_data[WIDTH-1]. Arithmetic left: vacated bits = 0.
- Amount >= WIDTH: logical -> all in_pad; arithmetic right -> all sign bit; arithmetic left -> 0; rotate -> amount mod WIDTH (MSB of in_amount ignored).
- Amount 0: out_data = in_data in every mode.
- out_data holds its value while out_valid && !out_ready; it is not cleared when out_valid falls.
- Simultaneous output pop and input push with a full pipe: both occur; no bubble inserted.
- out_valid stays asserted and out_data stable until accepted; operation order is preserved.

Optional Feature:
SHIFTER_PIPELINED_STICKY_EN: adds output out_sticky (1 bit) = OR of all bits shifted out past bit 0 for right shifts in logical/arithmetic mode (accumulated per stage, carried with the data); 0 for left and rotate. Reset value 0. Without the macro the port and sticky logic are absent.

Decomposition:
- Shared header shifter_modes: localparams SHIFT_MODE_LOGICAL=2'b00, SHIFT_MODE_ARITHMETIC=2'b01, SHIFT_MODE_ROTATE=2'b10, SHIFT_MODE_RESERVED=2'b11.
- Sub-module shifter_pipelined_stage: one register stage applying a contiguous range of shift levels (parameters FIRST_LEVEL, LEVEL_COUNT); top level generates STAGES instances and handles bit reversal and handshake chaining.

Test Plan:
- WIDTH=8, STAGES=2; logical right 0xB4 by 3, pad 0 -> 0x16 after 2 cycles; same op with pad 1 -> 0xF6; sticky=1 (bits 100 lost); 0xB4 by 2 -> sticky=0.
- Arithmetic right 0xB4 by 2 -> 0xED; 0x7F by 9 -> 0x00; 0x80 by 8 -> 0xFF; arithmetic left 0x81 by 1 -> 0x02.
- Rotate left 0xB4 by 3 -> 0xA5; by 11 -> 0xA5; rotate right 0xA5 by 3 -> 0xB4; any mode, amount 0 -> unchanged.
- Logical left 0x01 by 8, pad 1 -> 0xFF; mode 11 behaves as logical.
- Backpressure: push 6 back-to-back ops, out_ready low for 4 cycles -> in_ready drops once STAGES ops are held; all 6 results delivered in order, none lost or duplicated; out_data stable while stalled.
- Assert resetn low with 2 ops in flight -> out_valid=0 immediately, out_data=0; after release no stale result appears; the next op completes with normal latency.
